// File: rtl/dmem_lsu.sv
// ---------------------------------------------------------------------------
// dmem_lsu -- load/store unit driving a word-wide data memory with no byte
// enables. Takes one load/store per request from execute, maps the byte
// address onto the memory address, sign/zero-extends sub-word loads and
// performs SB/SH as read-modify-write.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req               request valid (sampled only while o_busy=0)
//   i_load / i_store    request type (exactly one must be set)
//   i_funct3            RV32I width/sign code
//   i_addr              byte address
//   i_store_data        rs2 value for stores
//   o_busy              high whenever the unit is not idle
//   o_done / o_error    one-cycle completion pulse / fault flag with it
//   o_load_data         extended load result, held until the next load
//   o_stb / o_wr_en     memory read strobe / write enable (never together)
//   o_addr              memory address (0 when bus idle)
//   o_write_data        memory write data (0 when bus idle)
//   i_rd_ack            memory read acknowledge
//   i_read_data         memory read data
// ---------------------------------------------------------------------------
module dmem_lsu #(
  parameter bit WORD_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_load_data,
  output logic        o_stb,
  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_write_data,
  input  logic        i_rd_ack,
  input  logic [31:0] i_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched request (data only, no reset needed)
  logic [31:0] r_req_addr;
  logic [2:0]  r_f3;
  logic        r_is_load;
  logic [31:0] r_sdata;

  // Registered outputs
  logic        r_busy, r_done, r_error, r_stb, r_wr_en;
  logic [31:0] r_addr, r_wdata, r_load_data;

  logic        w_acc;
  logic        w_err;
  logic        w_busy_nxt, w_done_nxt, w_error_nxt, w_stb_nxt, w_wr_en_nxt;
  logic [31:0] w_addr_src, w_addr_nxt, w_wdata_nxt, w_load_nxt;

  // Request is rejected for bad type, illegal funct3 or misalignment.
  function automatic logic req_fault(input logic ld, input logic st,
                                     input logic [2:0] f3, input logic [1:0] a);
    logic bad_type, bad_f3, misal;
    bad_type = (ld == st);
    bad_f3   = ld ? ((f3 == 3'b011) || (f3[2:1] == 2'b11)) : (f3 > 3'b010);
    misal    = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_type | bad_f3 | misal;
  endfunction

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    return WORD_ADDR ? {2'b00, a[31:2]} : {a[31:2], 2'b00};
  endfunction

  // Select byte/half lane from the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;
    b   = w[{a, 3'b000} +: 8];
    h   = w[{a[1], 4'b0000} +: 16];
    sgn = ~f3[2];
    case (f3[1:0])
      2'b00:   return {{24{b[7] & sgn}}, b};
      2'b01:   return {{16{h[15] & sgn}}, h};
      default: return w;
    endcase
  endfunction

  // Insert store byte/half into the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] m;
    m = w;
    if (f3[1:0] == 2'b00) m[{a, 3'b000} +: 8] = d[7:0];
    else                  m[{a[1], 4'b0000} +: 16] = d[15:0];
    return m;
  endfunction

  assign w_acc = (r_state == S_IDLE) && i_req;
  assign w_err = req_fault(i_load, i_store, i_funct3, i_addr[1:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_err)                      w_state_nxt = S_RESP;
          else if (i_load)                w_state_nxt = S_READ;
          else if (i_funct3[1:0] == 2'b10) w_state_nxt = S_WRITE;
          else                            w_state_nxt = S_READ;
        end
      end
      S_READ:  if (i_rd_ack) w_state_nxt = r_is_load ? S_RESP : S_WRITE;
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: values for the next cycle, registered below
  always_comb begin
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_RESP);
    w_error_nxt = w_acc && w_err;
    w_stb_nxt   = (w_state_nxt == S_READ);
    w_wr_en_nxt = (w_state_nxt == S_WRITE);
    w_addr_src  = (r_state == S_IDLE) ? i_addr : r_req_addr;
    w_addr_nxt  = (w_stb_nxt || w_wr_en_nxt) ? map_addr(w_addr_src) : 32'h0;
    w_wdata_nxt = 32'h0;
    if (w_wr_en_nxt) begin
      // SW goes straight from IDLE; SB/SH arrive here from READ with the ack word.
      w_wdata_nxt = (r_state == S_IDLE) ? i_store_data
                  : store_merge(i_read_data, r_sdata, r_f3, r_req_addr[1:0]);
    end
    w_load_nxt = r_load_data;
    if ((r_state == S_READ) && i_rd_ack && r_is_load)
      w_load_nxt = load_extend(i_read_data, r_f3, r_req_addr[1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_stb       <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_load_data <= 32'h0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
      r_stb       <= w_stb_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_load_data <= w_load_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_req_addr <= i_addr;
      r_f3       <= i_funct3;
      r_is_load  <= i_load;
      r_sdata    <= i_store_data;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_stb        = r_stb;
  assign o_wr_en      = r_wr_en;
  assign o_addr       = r_addr;
  assign o_write_data = r_wdata;
  assign o_load_data  = r_load_data;

endmodule

// File: tb/tb_dmem_lsu.sv
// ---------------------------------------------------------------------------
// Testbench for dmem_lsu: word memory model on the bus side with
// programmable ack delay, byte-level reference model for expected results.
// ---------------------------------------------------------------------------
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_load, i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_store_data;
  logic        o_busy, o_done, o_error;
  logic [31:0] o_load_data;
  logic        o_stb, o_wr_en;
  logic [31:0] o_addr, o_write_data;
  logic        i_rd_ack;
  logic [31:0] i_read_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic        mem_ready = 1'b0;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic [31:0] exp_ld_data = 32'h0;

  always #5 clk = ~clk;

  dmem_lsu #(.WORD_ADDR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_load(i_load), .i_store(i_store),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_load_data(o_load_data),
    .o_stb(o_stb), .o_wr_en(o_wr_en), .o_addr(o_addr), .o_write_data(o_write_data),
    .i_rd_ack(i_rd_ack), .i_read_data(i_read_data)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] k;
    k = 32'(i + 1);
    return (i == 5) ? 32'h8899AABB : ((32'h9E3779B9 * k) ^ 32'h0F0F1234);
  endfunction

  // Memory: writes on o_wr_en, read data and ack combinational with delay.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (o_wr_en) begin
      mem[o_addr[5:0]] <= o_write_data;
    end
    wait_cnt <= (o_stb && !i_rd_ack) ? wait_cnt + 1 : 0;
  end

  assign i_rd_ack    = o_stb && (wait_cnt >= ack_delay);
  assign i_read_data = o_stb ? mem[o_addr[5:0]] : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction, driven and checked against the reference model.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int dly, input bit noise);
    int          idx, size, sh, exp_lat, exp_stb, exp_wr, lat, n_stb, n_wr;
    logic        exp_err, got_err;
    logic [31:0] mask, w, v, new_w;
    idx  = int'(addr[7:2]);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    exp_err = (ld == st) || (ld ? (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 > 3'd2))
              || ((addr % 32'(size)) != 0);
    sh   = int'(addr % 4) * 8;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
    w     = ref_mem[idx];
    new_w = w;
    v     = exp_ld_data;
    if (!exp_err && ld) begin
      v = (w >> sh) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    end
    if (!exp_err && st) new_w = (w & ~(mask << sh)) | ((data & mask) << sh);
    if (exp_err)        begin exp_lat = 1;       exp_stb = 0;       exp_wr = 0; end
    else if (ld)        begin exp_lat = 2 + dly; exp_stb = 1 + dly; exp_wr = 0; end
    else if (size == 4) begin exp_lat = 2;       exp_stb = 0;       exp_wr = 1; end
    else                begin exp_lat = 3 + dly; exp_stb = 1 + dly; exp_wr = 1; end

    ack_delay = dly;
    @(negedge clk);
    for (int g = 0; g < 50 && o_busy; g++) @(negedge clk);
    check("idle_before", 32'(o_busy), 32'h0);
    i_req = 1'b1; i_load = ld; i_store = st; i_funct3 = f3;
    i_addr = addr; i_store_data = data;
    @(posedge clk);
    #1 i_req = 1'b0;
    lat = 0; n_stb = 0; n_wr = 0; got_err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      check("stb_wr_excl", 32'(o_stb & o_wr_en), 32'h0);
      check("busy_during", 32'(o_busy), 32'h1);
      if (o_stb || o_wr_en) begin
        check("bus_addr", o_addr, 32'(idx));
      end else begin
        check("idle_addr", o_addr, 32'h0);
        check("idle_wdata", o_write_data, 32'h0);
      end
      if (o_wr_en) check("write_data", o_write_data, new_w);
      if (o_stb)   n_stb++;
      if (o_wr_en) n_wr++;
      if (o_done) begin
        lat = k; got_err = o_error;
        break;
      end
      if (noise) begin
        i_req = 1'($urandom_range(0, 1)); i_load = 1'($urandom_range(0, 1));
        i_store = 1'($urandom_range(0, 1)); i_funct3 = 3'($urandom_range(0, 7));
        i_addr = $urandom; i_store_data = $urandom;
      end
    end
    i_req = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("error", 32'(got_err), 32'(exp_err));
    check("stb_cycles", 32'(n_stb), 32'(exp_stb));
    check("wr_cycles", 32'(n_wr), 32'(exp_wr));
    check("load_data", o_load_data, v);
    ref_mem[idx] = new_w;
    exp_ld_data  = v;
    check("mem_word", mem[idx], new_w);
    @(negedge clk);
    check("done_pulse", 32'(o_done), 32'h0);
    check("busy_after", 32'(o_busy), 32'h0);
  endtask

  initial begin
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0; i_req = 1'b0; i_load = 1'b0; i_store = 1'b0;
    i_funct3 = 3'd0; i_addr = 32'h0; i_store_data = 32'h0;
    #12;
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_error", 32'(o_error), 32'h0);
    check("rst_stb", 32'(o_stb), 32'h0);
    check("rst_wr_en", 32'(o_wr_en), 32'h0);
    check("rst_addr", o_addr, 32'h0);
    check("rst_wdata", o_write_data, 32'h0);
    check("rst_load", o_load_data, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Loads from mem[5]
    do_req(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 0, 1'b0);
    check("lw_plan", o_load_data, 32'h8899AABB);
    do_req(1'b1, 1'b0, 3'b000, 32'h17, 32'h0, 0, 1'b0);
    check("lb_plan", o_load_data, 32'hFFFFFF88);
    do_req(1'b1, 1'b0, 3'b100, 32'h17, 32'h0, 0, 1'b0);
    do_req(1'b1, 1'b0, 3'b001, 32'h16, 32'h0, 1, 1'b0);
    do_req(1'b1, 1'b0, 3'b101, 32'h14, 32'h0, 0, 1'b0);
    check("lhu_plan", o_load_data, 32'h0000AABB);
    // SB read-modify-write then read back
    do_req(1'b0, 1'b1, 3'b000, 32'h15, 32'h11223344, 0, 1'b0);
    do_req(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 0, 1'b0);
    check("sb_readback", o_load_data, 32'h889944BB);
    // Faults
    do_req(1'b0, 1'b1, 3'b001, 32'h13, 32'hCAFEF00D, 0, 1'b0);
    do_req(1'b1, 1'b0, 3'b011, 32'h14, 32'h0, 0, 1'b0);
    do_req(1'b1, 1'b1, 3'b010, 32'h14, 32'h0, 0, 1'b0);
    check("err_keeps_load", o_load_data, 32'h889944BB);
    // Ack stall with request noise while busy
    do_req(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 4, 1'b1);
    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 0, 1'b1);

    // Reset in the middle of an SH read phase
    @(negedge clk);
    ack_delay = 10;
    i_req = 1'b1; i_load = 1'b0; i_store = 1'b1; i_funct3 = 3'b001;
    i_addr = 32'h22; i_store_data = 32'h0000BEEF;
    @(posedge clk);
    #1 i_req = 1'b0;
    @(negedge clk);
    check("midrst_stb_before", 32'(o_stb), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stb", 32'(o_stb), 32'h0);
    check("midrst_wr_en", 32'(o_wr_en), 32'h0);
    check("midrst_busy", 32'(o_busy), 32'h0);
    check("midrst_load", o_load_data, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_ld_data = 32'h0;
    check("midrst_no_write", mem[8], ref_mem[8]);
    do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      begin ld = 1'b1; st = 1'b1; end
      else if (r == 1) begin ld = 1'b0; st = 1'b0; end
      else             begin ld = 1'($urandom_range(0, 1)); st = ~ld; end
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        r  = $urandom_range(0, 4);
        f3 = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : (r == 2) ? 3'd2 : (r == 3) ? 3'd4 : 3'd5;
        if (st && f3[2]) f3 = {1'b0, f3[1:0]};
      end
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) addr = addr & 32'hFFFF_FFFE;
      if ($urandom_range(0, 2) == 0) addr = addr & 32'hFFFF_FFFC;
      do_req(ld, st, f3, addr, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
